led_out: RTL
============

Name: led_out

Overview:
- Memory-mapped output device that drives the red LEDs from CPU stores. It is the write-direction counterpart of the key input device.
- CPU stores to DATA push patterns into a small FIFO. A drain FSM shows each pattern on the LEDs for a fixed hold time before moving to the next.
- CTRL exposes the READY (space available), BUSY, OVERRUN and IE bits. An interrupt line lets the CPU refill the FIFO.
- The block sits on the shared abus/dbus I/O bus next to the keys, switches and timer devices.

Parameters:
- DBITS, 32, bus data/address width.
- LBITS, 10, LED pattern width.
- DATA_ADDR, 32'hF0000004, DATA register address.
- CTRL_ADDR, 32'hF0000104, CTRL register address.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- HOLD_CYCLES, 1000, clock cycles each pattern is displayed; must be at least 1.
- READY_BIT, 0, CTRL bit meaning "FIFO not full".
- BUSY_BIT, 1, CTRL bit meaning "FIFO non-empty or hold in progress".
- OVERRUN_BIT, 2, CTRL sticky bit meaning "a write was dropped".
- IE_BIT, 8, CTRL interrupt enable.

Ports:
- clk  input  1  system clock; the block uses this single clock.
- init  input  1  synchronous active-high reset.
- abus  input  DBITS  bus address.
- dbus  inout  DBITS  bus data. Driven only on reads of this device; high-Z otherwise.
- we  input  1  bus write enable (1 = write, 0 = read).
- intr  output  1  level interrupt request.
- ledr  output  LBITS  current displayed LED pattern.

Behaviour:
- Reset (init=1 at a clock edge):
  - ledr=0.
  - FIFO empty, pointers and count = 0.
  - FSM goes to IDLE and the hold counter = 0.
  - OVERRUN=0, IE=0, so intr=0.
  - READY reads 1.
  - init has priority over every bus access and drain action in the same cycle.
  - Reset during HOLD aborts the hold immediately.
- Address decode:
  - selDATA = (abus==DATA_ADDR); selCTRL = (abus==CTRL_ADDR).
  - Reads are combinational: dbus = {0, ledr} for DATA, and the assembled CTRL word for CTRL.
  - On any other access dbus is {DBITS{1'bz}}.
- CTRL read value:
  - READY = !full.
  - BUSY = !empty || state==HOLD.
  - OVERRUN and IE as stored.
  - All other bits read 0.
- DATA write (we && selDATA):
  - If the FIFO is not full at the start of the cycle, push dbus[LBITS-1:0].
  - If it is full, drop the data and set OVERRUN. This holds even if a pop happens in the same cycle.
- CTRL write (we && selCTRL):
  - IE <= dbus[IE_BIT].
  - OVERRUN is cleared only if dbus[OVERRUN_BIT]==0; writing 1 leaves it unchanged.
  - If an overrun event and a clearing write occur in the same cycle, the set wins.
  - READY and BUSY are read-only.
- Drain FSM, states IDLE and HOLD:
  - IDLE with the FIFO non-empty: pop the head, ledr <= head on the same edge, hold counter <= HOLD_CYCLES-1, go to HOLD. If HOLD_CYCLES==1, stay in IDLE.
  - IDLE with the FIFO empty: stay in IDLE; ledr keeps its last value.
  - HOLD: decrement the counter; when it reaches 0, go to IDLE.
  - Required observable: with queued entries, ledr changes exactly every HOLD_CYCLES cycles.
- Latency: a store at edge t into an empty FIFO while in IDLE is popped at edge t+1, so ledr shows it from t+1 onward. A same-cycle bypass is not allowed.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when not full leaves the count unchanged.
- intr = READY && IE, registered-free and combinational from state. The ISR masks it by clearing IE when it has no more data.
- DATA read has no side effects: no pop and no flag change.

Decomposition:
- Shared package io_defs:
  - device address constants (DATA/CTRL pairs for keys and LEDs);
  - CTRL bit positions READY/BUSY/OVERRUN/IE;
  - DBITS.
- Sub-module sync_fifo:
  - parameters WIDTH and DEPTH;
  - ports clk, init, push, pop, din, dout (head, show-ahead), full, empty.
- The FSM, hold counter and bus decode stay in led_out.

Test Plan:
- Reset: hold init for 2 cycles, then read CTRL. Expect 32'h00000001 (READY only), ledr=0, intr=0, dbus=Z when the device is not selected.
- Single write: HOLD_CYCLES=4, write 0x2AA to DATA. Expect ledr=0x2AA one cycle later. BUSY=1 for 4 cycles from the pop, then CTRL reads 0x1.
- Burst and pacing: write 1, 2, 3, 4 on consecutive cycles. Expect ledr = 1, 2, 3, 4, changing exactly every 4 cycles, and READY=1 throughout.
- Overrun: use HOLD_CYCLES=1000 so nothing drains beyond the first pop. Write 6 values back-to-back. Expect values 1–5 accepted (1 displayed, 4 queued) and value 6 dropped. CTRL reads 0x6: READY=0, BUSY=1, OVERRUN=1. Writing CTRL=0x000 clears OVERRUN; writing 0x004 does not.
- Interrupt: write CTRL=0x100 with the FIFO not full and expect intr=1. Fill the FIFO and expect intr=0, then intr=1 again after the next pop. Write CTRL=0 and expect intr=0.
- Reset mid-hold: assert init while state==HOLD with 3 entries queued. Expect the next cycle to show ledr=0, CTRL=0x1, and no further LED changes.

Source files
------------

// File: rtl/io_defs.sv
// Shared definitions for the memory-mapped I/O devices on the abus/dbus bus:
// device addresses, CTRL bit positions and the LED drain FSM states.
package io_defs;

    localparam int DBITS = 32;

    localparam logic [31:0] KEY_DATA_ADDR = 32'hF0000000;
    localparam logic [31:0] KEY_CTRL_ADDR = 32'hF0000100;
    localparam logic [31:0] LED_DATA_ADDR = 32'hF0000004;
    localparam logic [31:0] LED_CTRL_ADDR = 32'hF0000104;

    localparam int READY_BIT   = 0;
    localparam int BUSY_BIT    = 1;
    localparam int OVERRUN_BIT = 2;
    localparam int IE_BIT      = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } led_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pushes while full and pops while empty
// are ignored. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             init,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/led_out.sv
// Red LED output device: CPU stores queue patterns, each shown on ledr
// for HOLD_CYCLES clocks; CTRL reports READY/BUSY/OVERRUN/IE.
module led_out
    import io_defs::*;
#(
    parameter int               DBITS       = io_defs::DBITS,
    parameter int               LBITS       = 10,
    parameter logic [DBITS-1:0] DATA_ADDR   = io_defs::LED_DATA_ADDR,
    parameter logic [DBITS-1:0] CTRL_ADDR   = io_defs::LED_CTRL_ADDR,
    parameter int               DEPTH       = 4,
    parameter int               HOLD_CYCLES = 1000,
    parameter int               READY_BIT   = io_defs::READY_BIT,
    parameter int               BUSY_BIT    = io_defs::BUSY_BIT,
    parameter int               OVERRUN_BIT = io_defs::OVERRUN_BIT,
    parameter int               IE_BIT      = io_defs::IE_BIT
) (
    input  logic             clk,
    input  logic             init,
    input  logic [DBITS-1:0] abus,
    inout  wire  [DBITS-1:0] dbus,
    input  logic             we,
    output logic             intr,
    output logic [LBITS-1:0] ledr
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    led_state_t       state;
    led_state_t       state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             pop;
    logic [LBITS-1:0] head;
    logic             full;
    logic             empty;
    logic             sel_data;
    logic             sel_ctrl;
    logic             wr_data;
    logic             wr_ctrl;
    logic             ov_set;
    logic             overrun;
    logic             ie;
    logic [DBITS-1:0] ctrl_word;
    logic [DBITS-1:0] rd_data;
    logic             unused_dbus;

    assign sel_data = (abus == DATA_ADDR);
    assign sel_ctrl = (abus == CTRL_ADDR);
    assign wr_data  = we && sel_data;
    assign wr_ctrl  = we && sel_ctrl;
    // full is sampled before this edge's pop, so a store into a full
    // FIFO is dropped even when the drain frees a slot in the same cycle
    assign ov_set   = wr_data && full;
    assign intr     = !full && ie;

    // only a few data bits are ever written into state
    assign unused_dbus = ^dbus;

    sync_fifo #(
        .WIDTH (LBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .init  (init),
        .push  (wr_data),
        .pop   (pop),
        .din   (dbus[LBITS-1:0]),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    cnt_nx = HOLD_LAST;
                    if (HOLD_CYCLES > 1)
                        state_nx = HOLD;
                end
            end
            HOLD: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CW'(1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state   <= IDLE;
            cnt     <= '0;
            ledr    <= '0;
            overrun <= 1'b0;
            ie      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (pop)
                ledr <= head;
            if (ov_set)
                overrun <= 1'b1;
            else if (wr_ctrl && !dbus[OVERRUN_BIT])
                overrun <= 1'b0;
            if (wr_ctrl)
                ie <= dbus[IE_BIT];
        end
    end

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[READY_BIT]   = !full;
        ctrl_word[BUSY_BIT]    = !empty || (state == HOLD);
        ctrl_word[OVERRUN_BIT] = overrun;
        ctrl_word[IE_BIT]      = ie;
        rd_data                = '0;
        unique case (1'b1)
            sel_data: rd_data = DBITS'(ledr);
            sel_ctrl: rd_data = ctrl_word;
            default:  rd_data = '0;
        endcase
    end

    assign dbus = (!we && (sel_data || sel_ctrl)) ? rd_data : {DBITS{1'bz}};

endmodule
